// File: rtl/mult_share_arbiter.sv
// Round-robin sharing of one pipelined multiplier among NUM_REQ requesters, with tag tracking
// and per-requester response registers. Optional statistics counters under MULT_ARB_STATS_EN.
module mult_share_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_LEN    = 32,
  parameter int MUL_LATENCY = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*DATA_LEN-1:0]  req_a,
  input  logic [NUM_REQ*DATA_LEN-1:0]  req_b,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [NUM_REQ-1:0]           rsp_valid,
  output logic [NUM_REQ*DATA_LEN-1:0]  rsp_data,
  input  logic [NUM_REQ-1:0]           rsp_ready,
  output logic [DATA_LEN-1:0]          mul_a,
  output logic [DATA_LEN-1:0]          mul_b,
  output logic                         mul_in_valid,
  output logic                         mul_reset,
  input  logic [DATA_LEN-1:0]          mul_result,
  output logic                         busy,
  output logic [31:0]                  stat_issue_cnt,
  output logic [31:0]                  stat_conflict_cnt
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MUL_LATENCY + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  logic [0:0]          state;
  logic [CNT_W-1:0]    flush_cnt;
  logic [IDX_W-1:0]    rr_ptr;
  logic [NUM_REQ-1:0]  pending;
  logic [NUM_REQ-1:0]  eligible;
  logic [NUM_REQ-1:0]  grant;
  logic [NUM_REQ-1:0]  rsp_fire;
  logic [IDX_W-1:0]    grant_idx;
  logic [IDX_W:0]      cand;
  logic                grant_any;
  logic                clear_work;
  logic                result_take;

  logic [DATA_LEN-1:0] op_a    [NUM_REQ];
  logic [DATA_LEN-1:0] op_b    [NUM_REQ];
  logic [DATA_LEN-1:0] rsp_arr [NUM_REQ];

  // Stage 0 rides alongside mul_a/mul_b; the remaining MUL_LATENCY stages follow the multiplier.
  logic                tag_vld_p [0:MUL_LATENCY];
  logic [IDX_W-1:0]    tag_idx_p [0:MUL_LATENCY];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_pack
    assign op_a[i] = req_a[i*DATA_LEN +: DATA_LEN];
    assign op_b[i] = req_b[i*DATA_LEN +: DATA_LEN];
    assign rsp_data[i*DATA_LEN +: DATA_LEN] = rsp_arr[i];
  end

  assign eligible    = (state == ST_RUN && !flush) ? (req_valid & ~pending) : '0;
  assign rsp_fire    = rsp_valid & rsp_ready;
  assign clear_work  = flush || (state == ST_FLUSH);
  assign result_take = tag_vld_p[MUL_LATENCY] && !clear_work;
  assign req_ready   = reset ? '0 : grant;
  assign mul_reset   = reset | (state == ST_FLUSH);
  assign busy        = (|pending) | (state != ST_RUN);

  // Round-robin scan starting one past the last winner.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NUM_REQ))
        cand = cand - (IDX_W+1)'(NUM_REQ);
      if (!grant_any && eligible[cand[IDX_W-1:0]]) begin
        grant_any               = 1'b1;
        grant_idx               = cand[IDX_W-1:0];
        grant[cand[IDX_W-1:0]]  = 1'b1;
      end
    end
  end

  // Control: FSM, round-robin pointer, pending flags, tag pipe and response valids.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_RUN;
      flush_cnt    <= '0;
      rr_ptr       <= LAST_IDX;
      pending      <= '0;
      mul_in_valid <= 1'b0;
      rsp_valid    <= '0;
      for (int s = 0; s <= MUL_LATENCY; s++) begin
        tag_vld_p[s] <= 1'b0;
        tag_idx_p[s] <= '0;
      end
    end else begin
      mul_in_valid <= grant_any;
      tag_vld_p[0] <= grant_any;
      tag_idx_p[0] <= grant_idx;
      for (int s = 1; s <= MUL_LATENCY; s++) begin
        tag_vld_p[s] <= tag_vld_p[s-1];
        tag_idx_p[s] <= tag_idx_p[s-1];
      end
      if (grant_any)
        rr_ptr <= grant_idx;
      pending   <= (pending & ~rsp_fire) | grant;
      rsp_valid <= rsp_valid & ~rsp_fire;
      if (result_take)
        rsp_valid[tag_idx_p[MUL_LATENCY]] <= 1'b1;

      if (flush) begin
        state     <= ST_FLUSH;
        flush_cnt <= CNT_W'(MUL_LATENCY);
      end else if (state == ST_FLUSH) begin
        if (flush_cnt <= CNT_W'(1))
          state <= ST_RUN;
        else
          flush_cnt <= flush_cnt - CNT_W'(1);
      end

      // Anything in flight at or during a flush is dropped, including a result landing now.
      if (clear_work) begin
        pending   <= '0;
        rsp_valid <= '0;
        for (int s = 1; s <= MUL_LATENCY; s++)
          tag_vld_p[s] <= 1'b0;
      end
    end
  end

  // Datapath: operand issue registers and per-requester result holding registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mul_a <= '0;
      mul_b <= '0;
      for (int i = 0; i < NUM_REQ; i++)
        rsp_arr[i] <= '0;
    end else begin
      if (grant_any) begin
        mul_a <= op_a[grant_idx];
        mul_b <= op_b[grant_idx];
      end else begin
        mul_a <= '0;
        mul_b <= '0;
      end
      if (result_take)
        rsp_arr[tag_idx_p[MUL_LATENCY]] <= mul_result;
    end
  end

`ifdef MULT_ARB_STATS_EN
  logic [31:0] issue_cnt;
  logic [31:0] conflict_cnt;
  logic        multi_elig;

  // At least two bits set: clearing the lowest set bit leaves something behind.
  assign multi_elig = |(eligible & (eligible - NUM_REQ'(1)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      issue_cnt    <= '0;
      conflict_cnt <= '0;
    end else begin
      issue_cnt    <= issue_cnt + 32'(grant_any);
      conflict_cnt <= conflict_cnt + 32'(multi_elig);
    end
  end

  assign stat_issue_cnt    = issue_cnt;
  assign stat_conflict_cnt = conflict_cnt;
`else
  assign stat_issue_cnt    = 32'd0;
  assign stat_conflict_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter with a two-stage multiplier model.
module tb_mult_share_arbiter;
  localparam int N = 4;
  localparam int W = 32;
`ifdef MULT_ARB_STATS_EN
  localparam logic [31:0] EXP_ISSUE_A = 32'd4;
  localparam logic [31:0] EXP_CONF_A  = 32'd3;
  localparam logic [31:0] EXP_ISSUE_B = 32'd11;
  localparam logic [31:0] EXP_CONF_B  = 32'd5;
`else
  localparam logic [31:0] EXP_ISSUE_A = 32'd0;
  localparam logic [31:0] EXP_CONF_A  = 32'd0;
  localparam logic [31:0] EXP_ISSUE_B = 32'd0;
  localparam logic [31:0] EXP_CONF_B  = 32'd0;
`endif

  logic           clk = 1'b0;
  logic           reset;
  logic           flush;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   rsp_valid;
  logic [N*W-1:0] rsp_data;
  logic [N-1:0]   rsp_ready;
  logic [W-1:0]   mul_a;
  logic [W-1:0]   mul_b;
  logic           mul_in_valid;
  logic           mul_reset;
  logic [W-1:0]   mul_result;
  logic           busy;
  logic [31:0]    stat_issue_cnt;
  logic [31:0]    stat_conflict_cnt;
  logic [W-1:0]   m1;

  int n_chk  = 0;
  int n_fail = 0;

  mult_share_arbiter #(.NUM_REQ(N), .DATA_LEN(W), .MUL_LATENCY(2)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
    .mul_a(mul_a), .mul_b(mul_b), .mul_in_valid(mul_in_valid), .mul_reset(mul_reset),
    .mul_result(mul_result), .busy(busy),
    .stat_issue_cnt(stat_issue_cnt), .stat_conflict_cnt(stat_conflict_cnt)
  );

  always #5 clk = ~clk;

  // Multiplier model: product registered twice, low W bits kept.
  always @(posedge clk) begin
    if (mul_reset) begin
      m1         <= '0;
      mul_result <= '0;
    end else begin
      m1         <= mul_a * mul_b;
      mul_result <= m1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  function automatic logic [W-1:0] rd(input int i);
    return rsp_data[i*W +: W];
  endfunction

  task automatic do_reset();
    reset = 1'b1; flush = 1'b0; req_valid = '0; rsp_ready = '0; req_a = '0; req_b = '0;
    step();
    step();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; rsp_ready = '0; req_a = '0; req_b = '0;
    req_valid = 4'hF;
    #1;
    n_chk++; if (req_ready !== 4'h0) begin n_fail++; $display("FAIL reset_ready got=%h exp=%h", req_ready, 4'h0); end
    n_chk++; if (rsp_valid !== 4'h0) begin n_fail++; $display("FAIL reset_rsp_valid got=%h exp=%h", rsp_valid, 4'h0); end
    n_chk++; if (mul_reset !== 1'b1) begin n_fail++; $display("FAIL reset_mul_reset got=%b exp=1", mul_reset); end
    step();
    n_chk++; if (mul_in_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mul_in_valid got=%b exp=0", mul_in_valid); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_chk++; if (rsp_data !== '0) begin n_fail++; $display("FAIL reset_rsp_data got=%h exp=0", rsp_data); end
    n_chk++; if (stat_issue_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_stat_issue got=%0d exp=0", stat_issue_cnt); end
    req_valid = '0;
    reset = 1'b0;
    #1;
    n_chk++; if (mul_reset !== 1'b0) begin n_fail++; $display("FAIL release_mul_reset got=%b exp=0", mul_reset); end
  endtask

  task automatic test_single();
    set_op(0, 32'd7, 32'd6);
    req_valid = 4'b0001;
    #1;
    n_chk++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL single_grant got=%b exp=0001", req_ready); end
    step();
    req_valid = '0;
    n_chk++; if (mul_in_valid !== 1'b1 || mul_a !== 32'd7 || mul_b !== 32'd6) begin n_fail++; $display("FAIL single_issue got v=%b a=%0d b=%0d exp v=1 a=7 b=6", mul_in_valid, mul_a, mul_b); end
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy got=%b exp=1", busy); end
    step();
    n_chk++; if (rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL single_early1 got=%b exp=0000", rsp_valid); end
    step();
    n_chk++; if (rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL single_early2 got=%b exp=0000", rsp_valid); end
    step();
    n_chk++; if (rsp_valid !== 4'b0001 || rd(0) !== 32'd42) begin n_fail++; $display("FAIL single_result got v=%b d=%0d exp v=0001 d=42", rsp_valid, rd(0)); end
    rsp_ready = 4'b0001;
    step();
    rsp_ready = '0;
    n_chk++; if (rsp_valid !== 4'b0000 || busy !== 1'b0) begin n_fail++; $display("FAIL single_handshake got v=%b busy=%b exp v=0000 busy=0", rsp_valid, busy); end
  endtask

  task automatic test_arbitration();
    do_reset();
    rsp_ready = 4'hF;
    for (int i = 0; i < N; i++) set_op(i, 32'(i + 1), 32'd5);
    req_valid = 4'hF;
    #1;
    n_chk++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL arb_grant0 got=%b exp=0001", req_ready); end
    for (int g = 1; g < N; g++) begin
      step();
      n_chk++; if (req_ready !== 4'(1 << g)) begin n_fail++; $display("FAIL arb_grant%0d got=%b exp=%b", g, req_ready, 4'(1 << g)); end
    end
    step();
    req_valid = '0;
    n_chk++; if (rsp_valid !== 4'b0001 || rd(0) !== 32'd5) begin n_fail++; $display("FAIL arb_result0 got v=%b d=%0d exp v=0001 d=5", rsp_valid, rd(0)); end
    for (int r = 1; r < N; r++) begin
      step();
      n_chk++; if (rsp_valid !== 4'(1 << r) || rd(r) !== 32'(5 * (r + 1))) begin n_fail++; $display("FAIL arb_result%0d got v=%b d=%0d exp v=%b d=%0d", r, rsp_valid, rd(r), 4'(1 << r), 5 * (r + 1)); end
    end
    step();
    n_chk++; if (rsp_valid !== 4'b0000 || busy !== 1'b0) begin n_fail++; $display("FAIL arb_drain got v=%b busy=%b exp v=0000 busy=0", rsp_valid, busy); end
    n_chk++; if (stat_issue_cnt !== EXP_ISSUE_A) begin n_fail++; $display("FAIL stats_issue got=%0d exp=%0d", stat_issue_cnt, EXP_ISSUE_A); end
    n_chk++; if (stat_conflict_cnt !== EXP_CONF_A) begin n_fail++; $display("FAIL stats_conflict got=%0d exp=%0d", stat_conflict_cnt, EXP_CONF_A); end
  endtask

  task automatic test_backpressure();
    rsp_ready = 4'b1101;
    set_op(1, 32'd9, 32'd9);
    req_valid = 4'b0010;
    #1;
    n_chk++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL bp_grant got=%b exp=0010", req_ready); end
    step();
    step();
    step();
    step();
    n_chk++; if (rsp_valid !== 4'b0010 || rd(1) !== 32'd81) begin n_fail++; $display("FAIL bp_result got v=%b d=%0d exp v=0010 d=81", rsp_valid, rd(1)); end
    for (int c = 0; c < 10; c++) begin
      set_op(1, 32'(c + 100), 32'd1);
      step();
      n_chk++; if (req_ready !== 4'b0000 || rsp_valid !== 4'b0010 || rd(1) !== 32'd81) begin n_fail++; $display("FAIL bp_hold%0d got rdy=%b v=%b d=%0d exp rdy=0000 v=0010 d=81", c, req_ready, rsp_valid, rd(1)); end
    end
    rsp_ready = 4'hF;
    set_op(1, 32'd3, 32'd3);
    #1;
    n_chk++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_handshake_cycle got=%b exp=0000", req_ready); end
    step();
    n_chk++; if (req_ready !== 4'b0010 || rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL bp_regrant got rdy=%b v=%b exp rdy=0010 v=0000", req_ready, rsp_valid); end
    step();
    req_valid = '0;
    step();
    step();
    step();
    n_chk++; if (rsp_valid !== 4'b0010 || rd(1) !== 32'd9) begin n_fail++; $display("FAIL bp_second got v=%b d=%0d exp v=0010 d=9", rsp_valid, rd(1)); end
    step();
  endtask

  task automatic test_wrap();
    rsp_ready = 4'hF;
    set_op(2, 32'hFFFF_FFFF, 32'd2);
    set_op(3, 32'd0, 32'd123);
    req_valid = 4'b1100;
    #1;
    n_chk++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL wrap_grant2 got=%b exp=0100", req_ready); end
    step();
    n_chk++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL wrap_grant3 got=%b exp=1000", req_ready); end
    step();
    req_valid = '0;
    step();
    step();
    n_chk++; if (rsp_valid !== 4'b0100 || rd(2) !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL wrap_overflow got v=%b d=%h exp v=0100 d=fffffffe", rsp_valid, rd(2)); end
    step();
    n_chk++; if (rsp_valid !== 4'b1000 || rd(3) !== 32'd0) begin n_fail++; $display("FAIL wrap_zero got v=%b d=%0d exp v=1000 d=0", rsp_valid, rd(3)); end
    step();
  endtask

  task automatic test_flush();
    rsp_ready = 4'hF;
    set_op(0, 32'd1, 32'd1);
    set_op(1, 32'd2, 32'd2);
    req_valid = 4'b0011;
    #1;
    n_chk++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL flush_grant0 got=%b exp=0001", req_ready); end
    step();
    n_chk++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL flush_grant1 got=%b exp=0010", req_ready); end
    step();
    set_op(2, 32'd5, 32'd5);
    req_valid = 4'b0100;
    flush = 1'b1;
    #1;
    n_chk++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL flush_beats_grant got=%b exp=0000", req_ready); end
    step();
    flush = 1'b0;
    set_op(0, 32'd3, 32'd4);
    req_valid = 4'b0001;
    #1;
    n_chk++; if (mul_reset !== 1'b1 || req_ready !== 4'b0000 || rsp_valid !== 4'b0000 || busy !== 1'b1 || mul_in_valid !== 1'b0) begin n_fail++; $display("FAIL flush_cycle1 got mr=%b rdy=%b v=%b busy=%b miv=%b exp mr=1 rdy=0000 v=0000 busy=1 miv=0", mul_reset, req_ready, rsp_valid, busy, mul_in_valid); end
    step();
    n_chk++; if (mul_reset !== 1'b1 || req_ready !== 4'b0000 || rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL flush_cycle2 got mr=%b rdy=%b v=%b exp mr=1 rdy=0000 v=0000", mul_reset, req_ready, rsp_valid); end
    step();
    n_chk++; if (mul_reset !== 1'b0 || req_ready !== 4'b0001 || rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL flush_resume got mr=%b rdy=%b v=%b exp mr=0 rdy=0001 v=0000", mul_reset, req_ready, rsp_valid); end
    step();
    req_valid = '0;
    for (int c = 0; c < 2; c++) begin
      step();
      n_chk++; if (rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL flush_quiet%0d got=%b exp=0000", c, rsp_valid); end
    end
    step();
    n_chk++; if (rsp_valid !== 4'b0001 || rd(0) !== 32'd12) begin n_fail++; $display("FAIL flush_after_op got v=%b d=%0d exp v=0001 d=12", rsp_valid, rd(0)); end
    step();
    n_chk++; if (stat_issue_cnt !== EXP_ISSUE_B) begin n_fail++; $display("FAIL stats_issue_total got=%0d exp=%0d", stat_issue_cnt, EXP_ISSUE_B); end
    n_chk++; if (stat_conflict_cnt !== EXP_CONF_B) begin n_fail++; $display("FAIL stats_conflict_total got=%0d exp=%0d", stat_conflict_cnt, EXP_CONF_B); end
  endtask

  task automatic test_reset_mid();
    rsp_ready = 4'hF;
    set_op(0, 32'd2, 32'd3);
    req_valid = 4'b0001;
    step();
    req_valid = '0;
    #2;
    reset = 1'b1;
    #1;
    n_chk++; if (mul_in_valid !== 1'b0 || mul_a !== 32'd0 || busy !== 1'b0 || stat_issue_cnt !== 32'd0) begin n_fail++; $display("FAIL mid_reset got miv=%b a=%0d busy=%b si=%0d exp miv=0 a=0 busy=0 si=0", mul_in_valid, mul_a, busy, stat_issue_cnt); end
    step();
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      n_chk++; if (rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL mid_reset_quiet%0d got=%b exp=0000", c, rsp_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_arbitration();
    test_backpressure();
    test_wrap();
    test_flush();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached with %0d checks done", n_chk);
    $fatal(1, "watchdog");
  end
endmodule
